// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase sequencer.
// Light words are {country g,y,r, highway g,y,r}.
package traffic_pkg;

   typedef enum logic [2:0] {
      HG  = 3'd0,
      HY  = 3'd1,
      AR1 = 3'd2,
      NG  = 3'd3,
      NY  = 3'd4,
      AR2 = 3'd5
   } state_t;

   localparam int CNT_W = 8;

   localparam logic [5:0] LIGHT_HG  = 6'b001_100;
   localparam logic [5:0] LIGHT_HY  = 6'b001_010;
   localparam logic [5:0] LIGHT_AR1 = 6'b001_001;
   localparam logic [5:0] LIGHT_NG  = 6'b100_001;
   localparam logic [5:0] LIGHT_NY  = 6'b010_001;
   localparam logic [5:0] LIGHT_AR2 = 6'b001_001;

   // Unused encodings fall back to all-red so a corrupted state never shows green.
   function automatic logic [5:0] light_of(input state_t s);
      case (s)
         HG:      light_of = LIGHT_HG;
         HY:      light_of = LIGHT_HY;
         AR1:     light_of = LIGHT_AR1;
         NG:      light_of = LIGHT_NG;
         NY:      light_of = LIGHT_NY;
         AR2:     light_of = LIGHT_AR2;
         default: light_of = LIGHT_AR1;
      endcase
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating down-counter timing each phase; reloaded by the sequencer on every
// state entry (and on reset), expired while the count sits at zero.
module phase_timer
   import traffic_pkg::*;
(
   input  logic             clk,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             expired
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (load) begin
         count_reg <= load_value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - CNT_W'(1);
      end
   end

   assign expired = (count_reg == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Highway / country-road signal sequencer with a pedestrian crossing on the
// highway. Moore FSM; all outputs are registered alongside the state.
module phase_sequencer
   import traffic_pkg::*;
#(
   parameter int LONG_T  = 25,
   parameter int SHORT_T = 4,
   parameter int CLEAR_T = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       car,
   input  logic       ped_req,
   output logic [5:0] light,
   output logic       ped_walk,
   output logic [2:0] phase
);

   state_t           state_reg, state_next;
   logic             ped_pending_reg, ped_pending_next;
   logic             ped_pending_ng_reg, ped_pending_ng_next;
   logic [5:0]       light_reg;
   logic             ped_walk_reg;
   logic             timer_load;
   logic [CNT_W-1:0] timer_load_value;
   logic             timer_expired;

   function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
      case (s)
         HY, NY:   dur_m1 = CNT_W'(SHORT_T - 1);
         AR1, AR2: dur_m1 = CNT_W'(CLEAR_T - 1);
         default:  dur_m1 = CNT_W'(LONG_T - 1);
      endcase
   endfunction

   phase_timer u_timer (
      .clk        (clk),
      .load       (timer_load),
      .load_value (timer_load_value),
      .expired    (timer_expired)
   );

   always_comb begin
      state_next          = state_reg;
      ped_pending_next    = ped_pending_reg | ped_req;
      ped_pending_ng_next = ped_pending_ng_reg;
      case (state_reg)
         HG:  if (timer_expired && (car || ped_pending_reg)) state_next = HY;
         HY:  if (timer_expired) state_next = AR1;
         AR1: if (timer_expired) begin
            // A request arriving on this very edge is served by the NG being entered.
            state_next          = NG;
            ped_pending_ng_next = ped_pending_reg | ped_req;
            ped_pending_next    = 1'b0;
         end
         NG:  if (timer_expired || (!car && !ped_pending_ng_reg)) state_next = NY;
         NY:  if (timer_expired) state_next = AR2;
         AR2: if (timer_expired) state_next = HG;
         default: state_next = HG;
      endcase
      timer_load       = rst || (state_next != state_reg);
      timer_load_value = rst ? CNT_W'(LONG_T - 1) : dur_m1(state_next);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg          <= HG;
         ped_pending_reg    <= 1'b0;
         ped_pending_ng_reg <= 1'b0;
         light_reg          <= LIGHT_HG;
         ped_walk_reg       <= 1'b0;
      end else begin
         state_reg          <= state_next;
         ped_pending_reg    <= ped_pending_next;
         ped_pending_ng_reg <= ped_pending_ng_next;
         light_reg          <= light_of(state_next);
         ped_walk_reg       <= (state_next == NG) && ped_pending_ng_next;
      end
   end

   assign light    = light_reg;
   assign ped_walk = ped_walk_reg;
   assign phase    = state_reg;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed, table-driven bench for phase_sequencer (LONG_T=8, SHORT_T=3, CLEAR_T=1)
// with a continuous road-conflict monitor.
module tb_phase_sequencer;
   import traffic_pkg::*;

   typedef struct {
      logic   car;
      logic   ped;
      state_t ph;
      logic   walk;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       car = 1'b0;
   logic       ped_req = 1'b0;
   logic [5:0] light;
   logic       ped_walk;
   logic [2:0] phase;

   int   total = 0;
   int   bad = 0;
   vec_t vecs[$];
   logic prev_cnt_act = 1'b0;
   logic prev_hwy_act = 1'b0;

   phase_sequencer #(.LONG_T(8), .SHORT_T(3), .CLEAR_T(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .car      (car),
      .ped_req  (ped_req),
      .light    (light),
      .ped_walk (ped_walk),
      .phase    (phase)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] exp_light(input state_t s);
      case (s)
         HG:      exp_light = 6'b001100;
         HY:      exp_light = 6'b001010;
         NG:      exp_light = 6'b100001;
         NY:      exp_light = 6'b010001;
         default: exp_light = 6'b001001;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic add(input logic c, input logic p, input state_t ph, input logic w, input int n);
      vec_t v;
      v.car = c; v.ped = p; v.ph = ph; v.walk = w;
      repeat (n) vecs.push_back(v);
   endtask

   task automatic do_reset();
      rst = 1'b1; car = 1'b0; ped_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Cycle i: drive inputs, check the outputs of the state held during cycle i.
   task automatic run_vecs(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         car = vecs[i].car;
         ped_req = vecs[i].ped;
         $display("%s cyc=%0d car=%0b ped=%0b phase=%0d light=%b walk=%0b",
                  tag, i, car, ped_req, phase, light, ped_walk);
         check({tag, " phase"}, 32'(phase), 32'(vecs[i].ph));
         check({tag, " light"}, 32'(light), 32'(exp_light(vecs[i].ph)));
         check({tag, " walk"}, 32'(ped_walk), 32'(vecs[i].walk));
         @(posedge clk); #1;
      end
      vecs.delete();
   endtask

   // Never green/yellow on both roads, one lamp per head, no direct road switch.
   always @(negedge clk) begin
      if (rst) begin
         prev_cnt_act <= 1'b0;
         prev_hwy_act <= 1'b0;
      end else begin
         total++;
         if ((light[5] | light[4]) && (light[2] | light[1])) begin
            bad++;
            $display("FAIL conflict actual=%b required=one road red", light);
         end
         total++;
         if ($countones(light[5:3]) != 1 || $countones(light[2:0]) != 1) begin
            bad++;
            $display("FAIL onehot actual=%b required=one lamp per road", light);
         end
         total++;
         if (((light[5] | light[4]) && prev_hwy_act) || ((light[2] | light[1]) && prev_cnt_act)) begin
            bad++;
            $display("FAIL allred_gap actual=%b required=all-red between roads", light);
         end
         prev_cnt_act <= light[5] | light[4];
         prev_hwy_act <= light[2] | light[1];
      end
   end

   initial begin
      // Reset state and idle hold
      do_reset();
      check("rst phase", 32'(phase), 32'(HG));
      check("rst light", 32'(light), 32'(6'b001100));
      check("rst walk", 32'(ped_walk), 32'd0);
      check("rst count", 32'(dut.u_timer.count_reg), 32'd7);
      check("rst pending", 32'(dut.ped_pending_reg), 32'd0);
      add(0, 0, HG, 0, 50);
      run_vecs("idle");

      // Continuous car demand: full cycle and back into HY
      do_reset();
      add(1, 0, HG, 0, 8); add(1, 0, HY, 0, 3); add(1, 0, AR1, 0, 1);
      add(1, 0, NG, 0, 8); add(1, 0, NY, 0, 3); add(1, 0, AR2, 0, 1);
      add(1, 0, HG, 0, 8); add(1, 0, HY, 0, 1);
      run_vecs("carcont");

      // Car leaves during NG: early gap-out one cycle later
      do_reset();
      add(1, 0, HG, 0, 8); add(1, 0, HY, 0, 3); add(1, 0, AR1, 0, 1);
      add(1, 0, NG, 0, 1); add(0, 0, NG, 0, 1); add(0, 0, NY, 0, 3);
      add(0, 0, AR2, 0, 1); add(0, 0, HG, 0, 10);
      run_vecs("carpulse");

      // Pedestrian only: full NG with walk, then rest in HG
      do_reset();
      add(0, 0, HG, 0, 2); add(0, 1, HG, 0, 1); add(0, 0, HG, 0, 5);
      add(0, 0, HY, 0, 3); add(0, 0, AR1, 0, 1); add(0, 0, NG, 1, 8);
      add(0, 0, NY, 0, 3); add(0, 0, AR2, 0, 1); add(0, 0, HG, 0, 10);
      run_vecs("ped");
      check("ped cleared", 32'(dut.ped_pending_reg), 32'd0);

      // Request on the AR1->NG edge is absorbed by that NG
      do_reset();
      add(1, 0, HG, 0, 8); add(0, 0, HY, 0, 3); add(0, 1, AR1, 0, 1);
      add(0, 0, NG, 1, 8); add(0, 0, NY, 0, 3); add(0, 0, AR2, 0, 1);
      add(0, 0, HG, 0, 12);
      run_vecs("pededge");
      check("pededge cleared", 32'(dut.ped_pending_reg), 32'd0);

      // Reset mid-NG overrides a simultaneous request
      do_reset();
      add(1, 0, HG, 0, 8); add(1, 0, HY, 0, 3); add(1, 0, AR1, 0, 1);
      add(1, 0, NG, 0, 3);
      run_vecs("midrst");
      check("midrst pre phase", 32'(phase), 32'(NG));
      check("midrst pre count", 32'(dut.u_timer.count_reg), 32'd4);
      rst = 1'b1; car = 1'b1; ped_req = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; ped_req = 1'b0; car = 1'b0;
      $display("midrst after reset phase=%0d light=%b walk=%0b", phase, light, ped_walk);
      check("midrst phase", 32'(phase), 32'(HG));
      check("midrst light", 32'(light), 32'(6'b001100));
      check("midrst walk", 32'(ped_walk), 32'd0);
      check("midrst count", 32'(dut.u_timer.count_reg), 32'd7);
      check("midrst pending", 32'(dut.ped_pending_reg), 32'd0);
      @(posedge clk); #1;
      check("midrst count next", 32'(dut.u_timer.count_reg), 32'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
